// File: rtl/sword_code_fsm.sv
// Sticky unlock flag that is set once a programmed sequence of switch presses is entered.
// Wrong entries are counted and trigger a timed lockout; idle gaps during entry abandon the attempt.
module sword_code_fsm #(
    parameter int N_SW = 4,
    parameter int SEQ_LEN = 3,
    parameter int IDX_W = $clog2(N_SW),
    parameter logic [SEQ_LEN*IDX_W-1:0] CODE = {2'd3, 2'd1, 2'd2},
    parameter int TIMEOUT = 16,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_SW-1:0]                sw,
    input  logic                           disarm,
    output logic                           v,
    output logic                           locked,
    output logic [$clog2(SEQ_LEN+1)-1:0]   progress,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries,
    output logic                           err_pulse
);

    localparam int PROG_W = $clog2(SEQ_LEN + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_ARMED,
        ST_LOCKOUT
    } state_t;

    state_t             state, state_nx;
    logic [N_SW-1:0]    sw_q;
    logic [PROG_W-1:0]  progress_nx;
    logic [TRY_W-1:0]   tries_nx;
    logic [IDLE_W-1:0]  idle_cnt, idle_cnt_nx;
    logic [LOCK_W-1:0]  lock_cnt, lock_cnt_nx;
    logic               err_nx;

    logic [N_SW-1:0]    press;
    logic               press_any;
    logic               press_single;
    logic [IDX_W-1:0]   press_idx;
    logic [IDX_W-1:0]   expected_idx;

    // A held switch yields exactly one press on its rising level.
    assign press        = sw & ~sw_q;
    assign press_any    = |press;
    assign press_single = $onehot(press);
    assign expected_idx = CODE[int'(progress)*IDX_W +: IDX_W];

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (press[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        progress_nx = progress;
        tries_nx    = tries;
        idle_cnt_nx = idle_cnt;
        lock_cnt_nx = lock_cnt;
        err_nx      = 1'b0;
        if (disarm) begin
            state_nx    = ST_IDLE;
            progress_nx = '0;
            tries_nx    = '0;
            idle_cnt_nx = '0;
            lock_cnt_nx = '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (press_any) begin
                        idle_cnt_nx = '0;
                        if (press_single && press_idx == expected_idx) begin
                            progress_nx = progress + PROG_W'(1);
                            state_nx    = (progress_nx == PROG_W'(SEQ_LEN)) ? ST_ARMED : ST_ENTRY;
                        end else begin
                            err_nx      = 1'b1;
                            progress_nx = '0;
                            tries_nx    = tries + TRY_W'(1);
                            if (tries_nx == TRY_W'(MAX_TRIES)) begin
                                state_nx    = ST_LOCKOUT;
                                lock_cnt_nx = '0;
                            end else begin
                                state_nx = ST_IDLE;
                            end
                        end
                    end else if (state == ST_ENTRY) begin
                        // Silent abandonment: the attempt is dropped without counting as wrong.
                        if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                            state_nx    = ST_IDLE;
                            progress_nx = '0;
                            idle_cnt_nx = '0;
                        end else begin
                            idle_cnt_nx = idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                ST_ARMED: begin
                end
                ST_LOCKOUT: begin
                    if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                        state_nx    = ST_IDLE;
                        tries_nx    = '0;
                        lock_cnt_nx = '0;
                    end else begin
                        lock_cnt_nx = lock_cnt + LOCK_W'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sw_q      <= '0;
            progress  <= '0;
            tries     <= '0;
            idle_cnt  <= '0;
            lock_cnt  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            sw_q      <= sw;
            progress  <= progress_nx;
            tries     <= tries_nx;
            idle_cnt  <= idle_cnt_nx;
            lock_cnt  <= lock_cnt_nx;
            err_pulse <= err_nx;
        end
    end

    assign v      = (state == ST_ARMED);
    assign locked = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_sword_code_fsm.sv
// Bench for sword_code_fsm: a cycle-count based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sword_code_fsm;

    localparam int N_SW        = 4;
    localparam int SEQ_LEN     = 3;
    localparam int TIMEOUT     = 16;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 32;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_ARMED = 2;
    localparam int M_LOCK  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_SW-1:0] sw;
    logic            disarm;
    logic            v;
    logic            locked;
    logic [1:0]      progress;
    logic [1:0]      tries;
    logic            err_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    sword_code_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .disarm    (disarm),
        .v         (v),
        .locked    (locked),
        .progress  (progress),
        .tries     (tries),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    int              code_seq [SEQ_LEN] = '{2, 1, 3};
    int              m_mode = M_IDLE;
    int              m_prog = 0;
    int              m_tries = 0;
    int              m_err = 0;
    int              m_last_press = 0;
    int              m_lock_end = 0;
    int              cyc = 0;
    logic [N_SW-1:0] m_prev = '0;
    logic [N_SW-1:0] m_press;
    bit              model_ok = 1'b0;

    // Deadlines are absolute cycle numbers rather than running down-counters.
    always @(posedge clk) begin
        cyc++;
        m_press = sw & ~m_prev;
        m_err   = 0;
        if (reset) begin
            m_mode   = M_IDLE;
            m_prog   = 0;
            m_tries  = 0;
            m_prev   = '0;
            model_ok = 1'b1;
        end else begin
            m_prev = sw;
            if (disarm) begin
                m_mode  = M_IDLE;
                m_prog  = 0;
                m_tries = 0;
            end else if (m_mode == M_LOCK) begin
                if (cyc >= m_lock_end) begin
                    m_mode  = M_IDLE;
                    m_tries = 0;
                end
            end else if (m_mode != M_ARMED) begin
                if (m_press != '0) begin
                    if ($countones(m_press) == 1 && m_press[code_seq[m_prog]]) begin
                        m_prog++;
                        m_last_press = cyc;
                        m_mode = (m_prog == SEQ_LEN) ? M_ARMED : M_ENTRY;
                    end else begin
                        m_err  = 1;
                        m_prog = 0;
                        m_tries++;
                        if (m_tries == MAX_TRIES) begin
                            m_mode     = M_LOCK;
                            m_lock_end = cyc + LOCK_CYCLES;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end else if (m_mode == M_ENTRY && cyc - m_last_press >= TIMEOUT) begin
                    m_mode = M_IDLE;
                    m_prog = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] got, want;
        if (model_ok) begin
            got  = {v, locked, progress, tries, err_pulse};
            want = {1'(m_mode == M_ARMED), 1'(m_mode == M_LOCK), 2'(m_prog), 2'(m_tries), 1'(m_err)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL model_cycle_%0d got v,lk,pr,tr,err=%b want %b", cyc, got, want);
            end
        end
    end

    task automatic check_output(input string name, input logic e_v, input logic e_locked,
                                input logic [1:0] e_prog, input logic [1:0] e_tries,
                                input logic e_err);
        logic [6:0] got, want;
        got  = {v, locked, progress, tries, err_pulse};
        want = {e_v, e_locked, e_prog, e_tries, e_err};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s got v,lk,pr,tr,err=%b want %b", name, got, want);
        end
    endtask

    task automatic press_key(input int idx, input int hold, input int gap);
        sw = '0;
        sw[idx] = 1'b1;
        repeat (hold) @(negedge clk);
        sw = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_disarm();
        disarm = 1'b1;
        @(negedge clk);
        disarm = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        sw     = '0;
        disarm = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_state", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        reset = 1'b0;

        // Correct sequence 2,1,3 then sticky v while ARMED.
        press_key(2, 2, 2);
        check_output("seq_prog1", 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
        press_key(1, 2, 2);
        check_output("seq_prog2", 1'b0, 1'b0, 2'd2, 2'd0, 1'b0);
        sw = 4'b1000;
        @(negedge clk);
        check_output("seq_unlock", 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        sw = '0;
        for (int i = 0; i < 25; i++) press_key(i % N_SW, 2, 2);
        check_output("armed_sticky", 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);

        // Wrong second press, then recovery.
        do_disarm();
        check_output("disarm_clear", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        press_key(2, 2, 2);
        sw = 4'b0001;
        @(negedge clk);
        check_output("wrong_err", 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        sw = '0;
        @(negedge clk);
        check_output("err_one_cycle", 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        press_key(2, 1, 1);
        press_key(1, 1, 1);
        press_key(3, 1, 1);
        check_output("retry_unlock", 1'b1, 1'b0, 2'd3, 2'd1, 1'b0);

        // Three wrong entries lock out for exactly LOCK_CYCLES.
        do_disarm();
        press_key(0, 1, 1);
        press_key(0, 1, 1);
        check_output("two_wrong", 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
        sw = 4'b0001;
        @(negedge clk);
        check_output("lockout_enter", 1'b0, 1'b1, 2'd0, 2'd3, 1'b1);
        sw = '0;
        press_key(2, 1, 1);
        press_key(1, 1, 1);
        press_key(3, 1, 1);
        check_output("lockout_ignores", 1'b0, 1'b1, 2'd0, 2'd3, 1'b0);
        repeat (25) @(negedge clk);
        check_output("lockout_last", 1'b0, 1'b1, 2'd0, 2'd3, 1'b0);
        @(negedge clk);
        check_output("lockout_exit", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        press_key(2, 1, 1);
        press_key(1, 1, 1);
        press_key(3, 1, 1);
        check_output("post_lock_unlock", 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);

        // Inter-press timeout.
        do_disarm();
        sw = 4'b0100;
        @(negedge clk);
        sw = '0;
        check_output("timeout_start", 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
        repeat (15) @(negedge clk);
        check_output("timeout_edge_minus1", 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
        @(negedge clk);
        check_output("timeout_fired", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        sw = 4'b0010;
        @(negedge clk);
        check_output("after_timeout_wrong", 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        sw = '0;
        @(negedge clk);

        // Simultaneous presses and a long hold.
        do_disarm();
        sw = 4'b0110;
        @(negedge clk);
        check_output("multi_press", 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        sw = '0;
        @(negedge clk);
        sw = 4'b0100;
        repeat (10) @(negedge clk);
        check_output("held_single", 1'b0, 1'b0, 2'd1, 2'd1, 1'b0);
        sw = '0;
        @(negedge clk);

        // Disarm from ARMED, reset mid-sequence, disarm with final press.
        do_disarm();
        press_key(2, 1, 1);
        press_key(1, 1, 1);
        press_key(3, 1, 1);
        check_output("armed_again", 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
        do_disarm();
        check_output("disarm_armed", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        press_key(2, 1, 1);
        press_key(1, 1, 1);
        check_output("mid_prog2", 1'b0, 1'b0, 2'd2, 2'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("reset_mid", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        press_key(2, 1, 1);
        press_key(1, 1, 1);
        sw     = 4'b1000;
        disarm = 1'b1;
        @(negedge clk);
        sw     = '0;
        disarm = 1'b0;
        check_output("disarm_final_press", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        check_output("disarm_final_after", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sword_code_fsm.md
Name: sword_code_fsm

Overview:
Parametrised successor to the single-switch sticky "sword" flag FSM. It watches N_SW switch inputs and asserts a sticky v only after the player presses a programmed sequence of SEQ_LEN switches in the correct order. Adds inter-press timeout, a wrong-entry counter with timed lockout, and an explicit disarm. Sits between the board switch synchronisers and the game-state logic.

Parameters:
N_SW, 4, number of switch inputs (>=2)
SEQ_LEN, 3, presses in the unlock sequence (>=1)
IDX_W, $clog2(N_SW), width of one code element (derived)
CODE, {2'd3,2'd1,2'd2}, packed sequence; element i at CODE[i*IDX_W +: IDX_W], element 0 pressed first (default sequence 2,1,3)
TIMEOUT, 16, idle cycles allowed between presses while in ENTRY (>=2)
MAX_TRIES, 3, wrong entries before lockout (>=1)
LOCK_CYCLES, 32, lockout duration in cycles (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high; overrides everything
sw  in  N_SW  switch levels, already synchronised to clk
disarm  in  1  returns FSM to IDLE, clears tries
v  out  1  sticky unlock flag
locked  out  1  high while in LOCKOUT
progress  out  $clog2(SEQ_LEN+1)  correct presses so far in the current attempt
tries  out  $clog2(MAX_TRIES+1)  wrong entries since last clear
err_pulse  out  1  one-cycle pulse after a wrong entry

Behaviour:
- Reset: state IDLE; v=0, locked=0, progress=0, tries=0, err_pulse=0; sw_q=0; all counters 0.
- Edge detect: press = sw & ~sw_q; sw_q <= sw every cycle, in every state, including during reset (loads 0 on reset). Held switch = one press only.
- Valid press: exactly one bit of press set. Two or more bits set in one cycle = wrong entry.
- Press decoded and state updated at the same edge at which sw is first sampled high; outputs reflect it the following cycle (1-cycle latency).
- States: IDLE, ENTRY, ARMED, LOCKOUT.
- IDLE/ENTRY, correct press (index == CODE[progress]): progress+1. If that reaches SEQ_LEN: go ARMED, v=1, progress=SEQ_LEN. Otherwise go/stay ENTRY. idle_cnt=0.
- IDLE/ENTRY, wrong press: err_pulse=1 next cycle, progress=0, tries+1. If new tries == MAX_TRIES: go LOCKOUT, locked=1, lock_cnt=0. Otherwise go IDLE.
- ENTRY, no press: idle_cnt+1. On the edge where idle_cnt==TIMEOUT-1: go IDLE, progress=0, tries unchanged, no err_pulse.
- IDLE, no press: hold; no timeout.
- ARMED: v held 1; presses ignored. Exit only via reset or disarm.
- LOCKOUT: presses ignored and not counted. lock_cnt+1 each cycle. On the edge where lock_cnt==LOCK_CYCLES-1: go IDLE, locked=0, tries=0.
- disarm (any state): next state IDLE, v=0, locked=0, progress=0, tries=0, counters 0. A press in the same cycle is ignored.
- Priority: reset > disarm > state-specific rules (within ENTRY: press > timeout).
- tries never exceeds MAX_TRIES; saturates by construction.
- SEQ_LEN==1: one correct press goes IDLE->ARMED directly.
- Reset mid-attempt or mid-lockout: immediate return to reset values at that edge.

Test Plan:
- Defaults; reset, then press sw[2], sw[1], sw[3], each held 2 cycles with 2 idle cycles between -> progress 1,2,3; v=1 one cycle after sw[3] is sampled; v stays 1 for 100 further cycles despite more presses.
- Press sw[2], then sw[0] -> err_pulse high for exactly 1 cycle, progress=0, tries=1, v=0; then correct 2,1,3 -> v=1.
- Three wrong presses (sw[0] x3, released between presses) -> tries=3, locked=1. Correct sequence during lockout -> ignored. locked falls exactly 32 cycles after entry, tries=0. Correct sequence afterwards -> v=1.
- Press sw[2], then wait 16 idle cycles -> progress returns to 0, tries=0, no err_pulse. Then press sw[1] -> wrong entry, tries=1.
- sw[2] and sw[1] rise in the same cycle from IDLE -> wrong entry, tries=1. Holding sw[2] high for 10 cycles -> counts as a single press, progress=1.
- From ARMED, assert disarm -> v=0 next cycle, state IDLE. Assert reset mid-sequence (progress=2) -> all outputs 0 next cycle. disarm coincident with a correct final press -> v stays 0.
